// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake for clk_div_ctrl: a half-period word offered with valid/ready.
interface clk_div_ctrl_if #(
   parameter int unsigned CNT_W = 19
);
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_half;
   logic             cfg_ready;

   modport master (
      output cfg_valid,
      output cfg_half,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_half,
      output cfg_ready
   );
endinterface

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider. Produces a registered square wave with a one-cycle
// tick on each rising edge; ratio changes are deferred to a falling edge so clk_o never glitches.
module clk_div_ctrl #(
   parameter int unsigned CNT_W        = 19,
   parameter int unsigned DEFAULT_HALF = 500000
) (
   input  logic          cristal_i,
   input  logic          RST_rst_i,
   input  logic          en_i,
   clk_div_ctrl_if.slave cfg,
   output logic          clk_o,
   output logic          tick_o,
   output logic          busy_o,
   output logic          cfg_err_o
);

   typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

   state_e           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_count, w_count_nxt;
   logic [CNT_W-1:0] r_half,  w_half_nxt;
   logic [CNT_W-1:0] r_pend,  w_pend_nxt;
   logic             r_clk,   w_clk_nxt;
   logic             r_tick,  w_tick_nxt;
   logic             r_err,   w_err_nxt;

   logic w_ready;
   logic w_busy;
   logic w_xfer;
   logic w_nz;
   logic w_term;

   assign w_xfer = cfg.cfg_valid & w_ready;
   assign w_nz   = (cfg.cfg_half != '0);
   // half_q is never zero, so half_q-1 cannot wrap
   assign w_term = (r_count == (r_half - CNT_W'(1)));

   // State register
   always_ff @(posedge cristal_i) begin
      if (!RST_rst_i) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath registers: counter, active/pending ratio, output wave and status
   always_ff @(posedge cristal_i) begin
      if (!RST_rst_i) begin
         r_count <= '0;
         r_half  <= CNT_W'(DEFAULT_HALF);
         r_pend  <= '0;
         r_clk   <= 1'b0;
         r_tick  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_half  <= w_half_nxt;
         r_pend  <= w_pend_nxt;
         r_clk   <= w_clk_nxt;
         r_tick  <= w_tick_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Next-state and datapath update
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_half_nxt  = r_half;
      w_pend_nxt  = r_pend;
      w_clk_nxt   = r_clk;
      w_tick_nxt  = 1'b0;
      w_err_nxt   = r_err;

      // Zero words are consumed but only raise the sticky error
      if (w_xfer) begin
         w_err_nxt = ~w_nz;
      end

      unique case (r_state)
         StIdle: begin
            w_count_nxt = '0;
            w_clk_nxt   = 1'b0;
            if (w_xfer && w_nz) begin
               w_half_nxt = cfg.cfg_half;
            end
            if (en_i) begin
               w_state_nxt = StRun;
            end
         end

         StRun: begin
            if (!en_i) begin
               w_state_nxt = StIdle;
               w_count_nxt = '0;
               w_clk_nxt   = 1'b0;
               if (w_xfer && w_nz) begin
                  w_half_nxt = cfg.cfg_half;
               end
            end else begin
               if (w_term) begin
                  w_count_nxt = '0;
                  w_clk_nxt   = ~r_clk;
                  w_tick_nxt  = ~r_clk;
               end else begin
                  w_count_nxt = r_count + CNT_W'(1);
               end
               if (w_xfer && w_nz) begin
                  w_pend_nxt  = cfg.cfg_half;
                  w_state_nxt = StPend;
               end
            end
         end

         StPend: begin
            if (!en_i) begin
               // Stopping commits the pending word so it is not lost
               w_state_nxt = StIdle;
               w_count_nxt = '0;
               w_clk_nxt   = 1'b0;
               w_half_nxt  = r_pend;
            end else if (w_term) begin
               w_count_nxt = '0;
               w_clk_nxt   = ~r_clk;
               w_tick_nxt  = ~r_clk;
               // Commit only on the 1->0 toggle so the new ratio starts a fresh low phase
               if (r_clk) begin
                  w_half_nxt  = r_pend;
                  w_state_nxt = StRun;
               end
            end else begin
               w_count_nxt = r_count + CNT_W'(1);
            end
         end

         default: begin
            w_state_nxt = StIdle;
            w_count_nxt = '0;
            w_clk_nxt   = 1'b0;
         end
      endcase
   end

   // State-decoded outputs
   always_comb begin
      w_ready = (r_state != StPend);
      w_busy  = (r_state == StPend);
   end

   assign cfg.cfg_ready = w_ready;
   assign busy_o        = w_busy;
   assign clk_o         = r_clk;
   assign tick_o        = r_tick;
   assign cfg_err_o     = r_err;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a phase-length model predicts each cycle's outputs,
// a separate monitor pops the predictions and compares them with the DUT.
module tb_clk_div_ctrl;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned DEF   = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en    = 1'b0;
   logic clk_o, tick_o, busy_o, err_o;

   always #5 clk = ~clk;

   clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

   clk_div_ctrl #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEF)
   ) dut (
      .cristal_i (clk),
      .RST_rst_i (rst_n),
      .en_i      (en),
      .cfg       (cfg_if),
      .clk_o     (clk_o),
      .tick_o    (tick_o),
      .busy_o    (busy_o),
      .cfg_err_o (err_o)
   );

   typedef struct packed {
      logic wave;
      logic tick;
      logic busy;
      logic ready;
      logic err;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: a running flag, the length of each phase, and how many cycles of the
   // current phase have elapsed; a waiting word takes effect when a low phase begins.
   bit m_run, m_pending, m_lvl, m_tick, m_err;
   int m_half, m_pend, m_age;

   task automatic model_step(input bit r, input bit e, input bit v, input int h);
      bit xfer;
      bit nz;
      if (!r) begin
         m_run = 0; m_pending = 0; m_lvl = 0; m_tick = 0; m_err = 0;
         m_half = DEF; m_pend = 0; m_age = 0;
         return;
      end
      xfer = v && !m_pending;
      nz   = (h != 0);
      if (xfer) m_err = !nz;
      m_tick = 0;
      if (!m_run) begin
         m_lvl = 0; m_age = 0;
         if (xfer && nz) m_half = h;
         m_run = e;
      end else if (!e) begin
         if (m_pending) m_half = m_pend;
         else if (xfer && nz) m_half = h;
         m_run = 0; m_pending = 0; m_lvl = 0; m_age = 0;
      end else begin
         m_age++;
         if (m_age == m_half) begin
            m_age  = 0;
            m_lvl  = !m_lvl;
            m_tick = m_lvl;
            if (!m_lvl && m_pending) begin
               m_half    = m_pend;
               m_pending = 0;
            end
         end
         if (xfer && nz) begin
            m_pend    = h;
            m_pending = 1;
         end
      end
   endtask

   task automatic step(input bit r, input bit e, input bit v, input int h);
      exp_t x;
      @(negedge clk);
      rst_n            = r;
      en               = e;
      cfg_if.cfg_valid = v;
      cfg_if.cfg_half  = h[CNT_W-1:0];
      model_step(r, e, v, h);
      x.wave  = m_lvl;
      x.tick  = m_tick;
      x.busy  = m_pending;
      x.ready = !m_pending;
      x.err   = m_err;
      exp_q.push_back(x);
   endtask

   task automatic run(input int n, input bit e);
      for (int i = 0; i < n; i++) step(1, e, 0, 0);
   endtask

   task automatic chk(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
      end
   endtask

   // Monitor: one prediction per clock edge, compared just after the edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("clk_o",       clk_o,            e.wave);
            chk("tick_o",      tick_o,           e.tick);
            chk("busy_o",      busy_o,           e.busy);
            chk("cfg_ready_o", cfg_if.cfg_ready, e.ready);
            chk("cfg_err_o",   err_o,            e.err);
         end
      end
   end

   initial begin
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_half  = '0;
      m_run = 0; m_pending = 0; m_lvl = 0; m_tick = 0; m_err = 0;
      m_half = DEF; m_pend = 0; m_age = 0;

      // 1: reset then run at the default ratio
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      run(2, 0);
      run(14, 1);

      // 2: new half-period 5 offered during the high phase
      for (int i = 0; i < 10 && !m_lvl; i++) step(1, 1, 0, 0);
      step(1, 1, 1, 5);
      run(26, 1);

      // 3: zero word rejected, then half-period 2
      step(1, 1, 1, 0);
      run(14, 1);
      step(1, 1, 1, 2);
      run(14, 1);

      // 4: half-period 1 loaded while idle, then divide by 2
      run(2, 0);
      step(1, 0, 1, 1);
      run(8, 1);

      // 5: word 7 pending when enable drops, then re-enable
      step(1, 1, 1, 7);
      run(3, 0);
      run(32, 1);

      // 6: reset during the high phase with a word pending and the error flag set
      step(1, 1, 1, 0);
      for (int i = 0; i < 20 && !m_lvl; i++) step(1, 1, 0, 0);
      step(1, 1, 1, 9);
      step(0, 1, 0, 0);
      run(14, 1);

      // Randomised traffic, including back-to-back words and overlapping events
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 299) != 0), ($urandom_range(0, 39) != 0),
              ($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)));
      end

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending predictions expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Runtime-programmable clock-divider controller driven directly from the board crystal. It produces a divided square wave and a one-cycle tick enable for downstream logic. A new half-period can be loaded through a valid/ready handshake; the ratio change is deferred to a full-period boundary so the output never glitches. Enable and error status are exposed to the top-level control logic.

Parameters:
CNT_W, 19, width of the half-period counter and of the config word.
DEFAULT_HALF, 500000, half-period in crystal cycles loaded at reset (100 Hz output from a 100 MHz crystal).

Ports:
cristal_i  in  1  crystal clock; the block's only clock.
RST_rst_i  in  1  reset; synchronous, active-low.
en_i  in  1  run enable; 1 = divide, 0 = hold the output low.
cfg_valid_i  in  1  config word valid.
cfg_half_i  in  CNT_W  requested half-period in crystal cycles; valid range 1..2^CNT_W-1.
cfg_ready_o  out  1  controller can accept a config word.
clk_o  out  1  divided square wave (registered).
tick_o  out  1  one-cycle pulse, high in the cycle clk_o goes 0->1.
busy_o  out  1  a config word is pending and not yet committed.
cfg_err_o  out  1  sticky flag: a zero half-period was rejected.

Behaviour:
- Internal registers: count (CNT_W), half_q (active half-period), pend_q (pending word), state {IDLE, RUN, PEND}.
- Reset (RST_rst_i=0 at a cristal_i edge), with priority over all other inputs:
  - count=0, half_q=DEFAULT_HALF, pend_q=0, state=IDLE.
  - clk_o=0, tick_o=0, busy_o=0, cfg_err_o=0; cfg_ready_o reads 1.
  - Reset mid-period or with a pending word discards all progress and the pending word.
- Handshake: a transfer occurs on a cycle where cfg_valid_i=1 and cfg_ready_o=1.
  - cfg_ready_o is combinational: 1 in IDLE and RUN, 0 in PEND.
  - busy_o=1 exactly while state=PEND.
- Zero word:
  - A transferred word with cfg_half_i=0 is consumed and discarded; cfg_err_o is set to 1 and the state is unchanged.
  - cfg_err_o clears on the next transferred nonzero word.
- IDLE:
  - count holds 0 and clk_o holds 0.
  - A transferred nonzero word goes directly into half_q.
  - en_i=1 -> RUN. count starts incrementing in the following cycle.
- RUN:
  - count increments each cycle.
  - When count==half_q-1: count<=0 and clk_o toggles.
  - On a 0->1 toggle, tick_o=1 for that one cycle only (registered with clk_o).
  - The output period is 2*half_q crystal cycles, high and low phases equal.
  - A transferred nonzero word -> pend_q, state PEND.
- PEND:
  - Division continues unchanged, using half_q.
  - On the terminal count where clk_o toggles 1->0, commit: half_q<=pend_q, state RUN. The new ratio applies from that low phase.
  - A commit never occurs on a 0->1 toggle.
- en_i=0 while in RUN or PEND, next cycle:
  - state IDLE, count=0, clk_o=0, tick_o=0.
  - In PEND, pend_q is committed into half_q, so the word is not lost.
- Simultaneous events:
  - Terminal count and transfer in RUN in the same cycle: the toggle uses the old half_q; the word goes pending.
  - en_i falling and a transfer in RUN in the same cycle: the word is committed to half_q and the state goes to IDLE.
- half_q=1: clk_o toggles every cycle (divide by 2); tick_o is high every second cycle.
- Arithmetic: the compare uses half_q-1 in CNT_W bits; half_q>=1 always holds because zero is never stored. count never exceeds half_q-1.

Test Plan:
Settings for all scenarios: CNT_W=4, DEFAULT_HALF=3.
1. Reset, then en_i=1 -> clk_o period 6 cycles (3 low, 3 high); tick_o high 1 cycle per period, coincident with clk_o rising; cfg_ready_o=1.
2. While running, transfer cfg_half_i=5 during the high phase -> busy_o=1 and cfg_ready_o=0 until the next falling edge; after the commit, the low and high phases are 5 cycles each.
3. Transfer cfg_half_i=0 -> cfg_err_o=1 and the period stays 6; then transfer 2 -> cfg_err_o=0 and the period becomes 4 after the next falling edge.
4. Transfer cfg_half_i=1 in IDLE, then en_i=1 -> clk_o alternates every cycle; tick_o toggles with period 2.
5. With a word pending (cfg_half_i=7), drop en_i -> next cycle state IDLE, clk_o=0, busy_o=0; re-enable -> phases are 7 cycles each.
6. Assert RST_rst_i=0 for 1 cycle mid high phase with a word pending -> clk_o=0, busy_o=0, cfg_err_o=0; on re-enable the period is 6.
